// File: rtl/mpi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mpi_pkg
// Brief    : Shared types and constants for the MPI bus-cycle engine.
// Revision : 1.0 - initial release
// ============================================================================
package mpi_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    ADDR  = 4'd1,
    ASYNC = 4'd2,
    DATA  = 4'd3,
    WRPLY = 4'd4,
    TERM  = 4'd5,
    END   = 4'd6,
    GRANT = 4'd7,
    DMA   = 4'd8
  } mpi_state_t;

  localparam logic [1:0] DATI  = 2'd0;
  localparam logic [1:0] DATO  = 2'd1;
  localparam logic [1:0] DATOB = 2'd2;

  localparam int c_tmo_def = 64;

  function automatic logic [1:0] cycle_kind(input logic we, input logic bsel);
    if (!we)
      return DATI;
    else if (bsel)
      return DATOB;
    else
      return DATO;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mpi_tmo_cnt.sv
`default_nettype none
// ============================================================================
// Module   : mpi_tmo_cnt
// Brief    : Saturating timeout counter with clear/enable and a programmable
//            expiry limit; shared by the reply-wait and release-wait phases.
// Revision : 1.0 - initial release
// ============================================================================
module mpi_tmo_cnt #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] lim,
  output logic         expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (clr)
      r_cnt <= '0;
    else if (en && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

  // Fires on the cycle whose increment would bring the count past lim
  assign expired = en && (r_cnt >= lim);

endmodule
`default_nettype wire

// File: rtl/mpi_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : mpi_bus_master
// Brief    : MPI (Q-bus style) DATI/DATO/DATOB bus-cycle master with RPLY
//            timeout. Optional DMA grant arbiter enabled by MPI_DMA_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mpi_bus_master
  import mpi_pkg::*;
#(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int TMO    = c_tmo_def,
  parameter int ASETUP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic          bsel,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ack,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] ad_o,
  output logic          ad_oe,
  input  logic [AW-1:0] ad_i,
  output logic          sync,
  output logic          din,
  output logic          dout,
  output logic          wtbt,
  input  logic          rply,
  input  logic          dmr,
  input  logic          sack,
  output logic          dmgo
);

  localparam int              c_cw    = $clog2(TMO) + 1;
  localparam int              c_sw    = (ASETUP > 1) ? $clog2(ASETUP) : 1;
  localparam logic [c_cw-1:0] c_lim   = c_cw'(TMO - 2);
  localparam logic [c_sw-1:0] c_slast = c_sw'(ASETUP - 1);

  mpi_state_t      r_state, w_next;
  logic [1:0]      r_kind;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rdata;
  logic            r_err;
  logic [c_sw-1:0] r_scnt;

  logic            w_we, w_byte, w_exp, w_clr, w_en, w_dmr_idle;
  logic [AW-1:0]   w_wdata_ext;
  logic [DW-1:0]   w_ad_lo;

  assign w_we   = (r_kind != DATI);
  assign w_byte = (r_kind == DATOB);

  if (AW > DW) begin : g_ad_wide
    logic w_unused_adhi;
    assign w_wdata_ext   = {{(AW-DW){1'b0}}, r_wdata};
    assign w_unused_adhi = ^ad_i[AW-1:DW];
  end else begin : g_ad_same
    assign w_wdata_ext = r_wdata;
  end
  assign w_ad_lo = ad_i[DW-1:0];

`ifdef MPI_DMA_EN
  assign w_dmr_idle = dmr;
`else
  logic w_unused_dma;
  assign w_dmr_idle   = 1'b0;
  assign w_unused_dma = dmr ^ sack;
`endif

  // Counter restarts on entry to WRPLY and again on entry to TERM
  assign w_clr = (r_state == DATA) || ((r_state == WRPLY) && (rply || w_exp));
  assign w_en  = (r_state == WRPLY) || (r_state == TERM);

  mpi_tmo_cnt #(.W(c_cw)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_clr),
    .en      (w_en),
    .lim     (c_lim),
    .expired (w_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    ad_o   = '0;
    ad_oe  = 1'b0;
    sync   = 1'b0;
    din    = 1'b0;
    dout   = 1'b0;
    wtbt   = 1'b0;
    ack    = 1'b0;
    err    = 1'b0;
    dmgo   = 1'b0;
    busy   = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_dmr_idle)
          w_next = GRANT;
        else if (req)
          w_next = ADDR;
      end
      ADDR: begin
        ad_o  = r_addr;
        ad_oe = 1'b1;
        wtbt  = w_we;
        if (r_scnt == c_slast)
          w_next = ASYNC;
      end
      ASYNC: begin
        ad_o   = r_addr;
        ad_oe  = 1'b1;
        wtbt   = w_we;
        sync   = 1'b1;
        w_next = DATA;
      end
      DATA: begin
        sync   = 1'b1;
        w_next = WRPLY;
        if (w_we) begin
          ad_o  = w_wdata_ext;
          ad_oe = 1'b1;
          wtbt  = w_byte;
          dout  = 1'b1;
        end
      end
      WRPLY: begin
        sync = 1'b1;
        if (w_we) begin
          ad_o  = w_wdata_ext;
          ad_oe = 1'b1;
          wtbt  = w_byte;
          dout  = 1'b1;
        end else begin
          din = 1'b1;
        end
        if (rply || w_exp)
          w_next = TERM;
      end
      TERM: begin
        sync = 1'b1;
        if (!rply || w_exp)
          w_next = END;
      end
      END: begin
        ack    = 1'b1;
        err    = r_err;
        w_next = IDLE;
      end
`ifdef MPI_DMA_EN
      GRANT: begin
        dmgo = 1'b1;
        if (sack)
          w_next = DMA;
        else if (!dmr)
          w_next = IDLE;
      end
      DMA: begin
        if (!sack)
          w_next = IDLE;
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kind  <= DATI;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_scnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_next == ADDR) begin
            r_kind  <= cycle_kind(we, bsel);
            r_addr  <= addr;
            r_wdata <= wdata;
            r_err   <= 1'b0;
            r_scnt  <= '0;
          end
        end
        ADDR:  r_scnt <= r_scnt + 1'b1;
        WRPLY: begin
          if (rply) begin
            if (!w_we)
              r_rdata <= w_ad_lo;
          end else if (w_exp) begin
            r_err <= 1'b1;
          end
        end
        TERM: begin
          if (rply && w_exp)
            r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mpi_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mpi_bus_master
// Brief    : Directed scoreboard bench for mpi_bus_master (16-bit and 22-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mpi_bus_master;

  localparam int TMO  = 64;
  localparam int TMO2 = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        req, we, bsel, ack, err, busy, ad_oe, sync, din, dout, wtbt, rply;
  logic        dmr, sack, dmgo;
  logic [15:0] addr, wdata, rdata, ad_o, ad_i;

  // 22-bit instance
  logic        req2, we2, bsel2, ack2, err2, busy2, ad_oe2, sync2, din2, dout2, wtbt2, rply2;
  logic        dmr2, sack2, dmgo2;
  logic [21:0] addr2, ad_o2, ad_i2;
  logic [15:0] wdata2, rdata2;

  mpi_bus_master #(.AW(16), .DW(16), .TMO(TMO), .ASETUP(1)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .bsel(bsel), .addr(addr), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy), .ad_o(ad_o), .ad_oe(ad_oe),
    .ad_i(ad_i), .sync(sync), .din(din), .dout(dout), .wtbt(wtbt), .rply(rply),
    .dmr(dmr), .sack(sack), .dmgo(dmgo)
  );

  mpi_bus_master #(.AW(22), .DW(16), .TMO(TMO2), .ASETUP(2)) u_dut22 (
    .clk(clk), .rst(rst), .req(req2), .we(we2), .bsel(bsel2), .addr(addr2), .wdata(wdata2),
    .ack(ack2), .err(err2), .rdata(rdata2), .busy(busy2), .ad_o(ad_o2), .ad_oe(ad_oe2),
    .ad_i(ad_i2), .sync(sync2), .din(din2), .dout(dout2), .wtbt(wtbt2), .rply(rply2),
    .dmr(dmr2), .sack(sack2), .dmgo(dmgo2)
  );

  typedef struct {
    logic [15:0] rd;
    logic        chk_rd;
    logic        er;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic pop_chk(input logic e_obs, input logic [15:0] rd_obs);
    exp_t e;
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("err", e_obs, e.er);
      if (e.chk_rd) chk("rdata", rd_obs, e.rd);
    end
  endtask

  // Drives one client request and plays the bus slave; dly = cycles of
  // DIN/DOUT before RPLY, respond=0 models an absent device.
  task automatic run_main(input logic w, input logic b, input logic [15:0] a,
                          input logic [15:0] wd, input logic [15:0] resp, input int dly,
                          input bit respond, output int lat, output int d2a);
    exp_t        e;
    int          acks, ack_cyc, din_cyc, dcnt;
    bit          ovl_ok, brk_ok;
    logic        psync, wa, wdt;
    logic [15:0] aobs, dobs;
    acks = 0; ack_cyc = -1; din_cyc = -1; dcnt = 0;
    ovl_ok = 1; brk_ok = 1; psync = 1'b0;
    wa = 1'bx; wdt = 1'bx; aobs = 'x; dobs = 'x;
    @(negedge clk);
    req = 1'b1; we = w; bsel = b; addr = a; wdata = wd;
    e.rd = resp; e.chk_rd = !w && respond; e.er = !respond;
    sb.push_back(e);
    for (int i = 1; i <= 3 * TMO; i++) begin
      @(negedge clk);
      if (din && dout) ovl_ok = 0;
      if ((din || dout) && !sync) brk_ok = 0;
      if (sync && !psync) begin aobs = ad_o; wa = wtbt; end
      if ((din || dout) && din_cyc < 0) begin
        din_cyc = i;
        if (!psync) brk_ok = 0;
      end
      if (dout) begin dobs = ad_o; wdt = wtbt; end
      psync = sync;
      if ((din || dout) && respond) begin
        dcnt++;
        if (dcnt > dly) begin rply = 1'b1; ad_i = resp; end
      end else begin
        rply = 1'b0; ad_i = 16'hA5C3;
      end
      if (ack) begin
        acks++;
        if (ack_cyc < 0) begin
          ack_cyc = i;
          req = 1'b0;
          pop_chk(err, rdata);
        end
      end
      if (ack_cyc > 0 && i >= ack_cyc + 3) break;
    end
    req = 1'b0; rply = 1'b0;
    chk("ack_seen", ack_cyc > 0, 1);
    chk("ack_once", acks, 1);
    chk("no_overlap", ovl_ok, 1);
    chk("sync_brackets", brk_ok, 1);
    chk("addr_phase", aobs, a);
    chk("wtbt_addr", wa, w);
    if (w) begin
      chk("data_phase", dobs, wd);
      chk("wtbt_data", wdt, b);
    end
    chk("sync_released", sync, 0);
    chk("idle_after", busy, 0);
    lat = ack_cyc;
    d2a = ack_cyc - din_cyc;
  endtask

  // Read on the 22-bit instance; stuck=1 holds RPLY high throughout.
  task automatic run_22(input logic [21:0] a, input logic [21:0] resp, input bit stuck,
                        output int lat, output logic [21:0] aobs);
    exp_t e;
    int   ack_cyc;
    logic psync;
    ack_cyc = -1; psync = 1'b0; aobs = 'x;
    if (stuck) begin rply2 = 1'b1; ad_i2 = resp; end
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b0; addr2 = a;
    e.rd = resp[15:0]; e.chk_rd = 1'b1; e.er = stuck;
    sb.push_back(e);
    for (int i = 1; i <= 4 * TMO2 + 16; i++) begin
      @(negedge clk);
      if (sync2 && !psync) aobs = ad_o2;
      psync = sync2;
      if (stuck || din2) begin rply2 = 1'b1; ad_i2 = resp; end
      else begin rply2 = 1'b0; ad_i2 = 22'h15A5A5; end
      if (ack2 && ack_cyc < 0) begin
        ack_cyc = i;
        req2 = 1'b0;
        pop_chk(err2, rdata2);
      end
      if (ack_cyc > 0 && i >= ack_cyc + 2) break;
    end
    req2 = 1'b0; rply2 = 1'b0;
    chk("ack22_seen", ack_cyc > 0, 1);
    chk("sync22_released", sync2, 0);
    lat = ack_cyc;
  endtask

  int          lat, d2a, acks;
  bit          ok;
  logic [21:0] aobs22;

  initial begin
    rst = 1'b1;
    req = 0; we = 0; bsel = 0; addr = '0; wdata = '0; rply = 0; ad_i = '0; dmr = 0; sack = 0;
    req2 = 0; we2 = 0; bsel2 = 0; addr2 = '0; wdata2 = '0; rply2 = 0; ad_i2 = '0; dmr2 = 0; sack2 = 0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {busy, ack, err, sync, din, dout, wtbt, ad_oe, dmgo}, 9'b0);
    chk("rst_ad_o", ad_o, 16'h0);
    chk("rst_rdata", rdata, 16'h0);
    rst = 1'b0;

    // Read, device replies after 3 cycles of DIN
    run_main(1'b0, 1'b0, 16'o177560, 16'h0, 16'h1234, 3, 1'b1, lat, d2a);
    chk("read_latency", lat, 9);
    // Minimum-latency read
    run_main(1'b0, 1'b0, 16'h1000, 16'h0, 16'h0F0F, 0, 1'b1, lat, d2a);
    chk("read_min_latency", lat, 6);
    // Word write
    run_main(1'b1, 1'b0, 16'o160000, 16'hBEEF, 16'h0, 1, 1'b1, lat, d2a);
    // Byte write, odd address
    run_main(1'b1, 1'b1, 16'o160001, 16'h00A5, 16'h0, 0, 1'b1, lat, d2a);
    // No responder
    run_main(1'b0, 1'b0, 16'h2000, 16'h0, 16'h0, 0, 1'b0, lat, d2a);
    chk("timeout_din_to_ack", d2a, TMO);

`ifdef MPI_DMA_EN
    @(negedge clk);
    dmr = 1'b1; req = 1'b1; we = 1'b0; addr = 16'h4000;
    @(negedge clk);
    chk("dmgo_first", dmgo, 1);
    chk("no_sync_in_grant", sync, 0);
    sack = 1'b1;
    @(negedge clk);
    dmr = 1'b0;
    ok = 1;
    repeat (10) begin
      @(negedge clk);
      if (sync || ad_oe || dmgo || din || dout || !busy) ok = 0;
    end
    chk("dma_bus_released", ok, 1);
    sack = 1'b0;
    run_main(1'b0, 1'b0, 16'h4000, 16'h0, 16'h5678, 0, 1'b1, lat, d2a);
    chk("read_after_dma", lat, 6);
`else
    dmr = 1'b1; sack = 1'b1;
    run_main(1'b0, 1'b0, 16'h4000, 16'h0, 16'h5678, 0, 1'b1, lat, d2a);
    chk("dma_ignored_latency", lat, 6);
    chk("dmgo_tied", dmgo, 0);
    dmr = 1'b0; sack = 1'b0;
`endif

    // 22-bit address bus
    run_22(22'h3FFFFE, 22'h3C1234, 1'b0, lat, aobs22);
    chk("addr22_phase", aobs22, 22'h3FFFFE);
    chk("read22_latency", lat, 7);
    // RPLY stuck high: reply accepted, release never comes
    run_22(22'h000100, 22'h00BEEF, 1'b1, lat, aobs22);
    chk("addr22_stuck", aobs22, 22'h000100);

    // Asynchronous reset in the middle of WRPLY
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 16'h3000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (din) break;
    end
    chk("din_before_rst", din, 1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ctrl", {busy, ack, err, sync, din, dout, wtbt, ad_oe}, 8'b0);
    chk("rst_mid_ad_o", ad_o, 16'h0);
    chk("rst_mid_rdata", rdata, 16'h0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("no_ack_after_rst", acks, 0);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
